sync_fifo: RTL and testbench

Parametrised single-clock FIFO that replaces the vendor FIFO IP in same-clock experiments and datapaths. It is built from an inferred register array with binary pointers and a registered occupancy count. It adds almost-full/almost-empty thresholds, a selectable show-ahead (first-word-fall-through) read mode, and sticky overflow/underflow error flags. Writer and reader logic connect to it exactly as they do to the IP FIFO, through wrreq/data and rdreq/q.

---
 rtl/sync_fifo_if.sv | 28 ++
 rtl/sync_fifo.sv | 78 +++++++
 tb/tb_sync_fifo.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sync_fifo_if.sv
// sync_fifo_if: writer/reader handshake bundle for sync_fifo
interface sync_fifo_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
);
    logic              wrreq;
    logic [DATA_W-1:0] data;
    logic              rdreq;
    logic              err_clr;
    logic [DATA_W-1:0] q;
    logic              empty;
    logic              full;
    logic              almost_empty;
    logic              almost_full;
    logic [ADDR_W:0]   usedw;
    logic              ovf;
    logic              udf;

    modport master (
        output wrreq, data, rdreq, err_clr,
        input  q, empty, full, almost_empty, almost_full, usedw, ovf, udf
    );

    modport slave (
        input  wrreq, data, rdreq, err_clr,
        output q, empty, full, almost_empty, almost_full, usedw, ovf, udf
    );
endinterface

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock register-array FIFO with registered count/flags,
// almost thresholds, optional show-ahead read and sticky ovf/udf flags.
module sync_fifo #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 4,
    parameter int AFULL_TH  = (1 << ADDR_W) - 2,
    parameter int AEMPTY_TH = 2,
    parameter int FWFT      = 0
) (
    input logic       sys_clk,
    input logic       sys_rst_n,
    sync_fifo_if.slave bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0] AF_W    = (ADDR_W + 1)'(AFULL_TH);
    localparam logic [ADDR_W:0] AE_W    = (ADDR_W + 1)'(AEMPTY_TH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr, rd_ptr;
    logic [ADDR_W:0]   usedw, usedw_nxt;
    logic              empty, full, almost_empty, almost_full, ovf, udf;
    logic              wr_en, rd_en;

    assign wr_en = bus.wrreq & ~full;
    assign rd_en = bus.rdreq & ~empty;

    always_comb
        usedw_nxt = (wr_en && !rd_en) ? usedw + 1'b1 :
                    (rd_en && !wr_en) ? usedw - 1'b1 : usedw;

    always_ff @(posedge sys_clk or negedge sys_rst_n)
        if (!sys_rst_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            usedw        <= '0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            ovf          <= 1'b0;
            udf          <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (rd_en) rd_ptr <= rd_ptr + 1'b1;
            usedw        <= usedw_nxt;
            empty        <= usedw_nxt == '0;
            full         <= usedw_nxt == DEPTH_W;
            almost_empty <= usedw_nxt <= AE_W;
            almost_full  <= usedw_nxt >= AF_W;
            // a new error on the same edge as err_clr keeps the flag set
            ovf          <= (bus.wrreq & full) | (ovf & ~bus.err_clr);
            udf          <= (bus.rdreq & empty) | (udf & ~bus.err_clr);
        end

    always_ff @(posedge sys_clk)
        if (wr_en) mem[wr_ptr] <= bus.data;

    generate
        if (FWFT != 0) begin : g_fwft
            assign bus.q = mem[rd_ptr];
        end else begin : g_norm
            logic [DATA_W-1:0] q_r;
            always_ff @(posedge sys_clk or negedge sys_rst_n)
                if (!sys_rst_n) q_r <= '0;
                else if (rd_en) q_r <= mem[rd_ptr];
            assign bus.q = q_r;
        end
    endgenerate

    assign bus.empty        = empty;
    assign bus.full         = full;
    assign bus.almost_empty = almost_empty;
    assign bus.almost_full  = almost_full;
    assign bus.usedw        = usedw;
    assign bus.ovf          = ovf;
    assign bus.udf          = udf;
endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: directed scenarios on a normal-mode and a show-ahead sync_fifo
module tb_sync_fifo;
    logic sys_clk = 1'b0;
    logic sys_rst_n = 1'b0;
    int checks = 0;
    int errors = 0;

    always #5 sys_clk = ~sys_clk;

    sync_fifo_if #(.DATA_W(8), .ADDR_W(4)) n ();
    sync_fifo_if #(.DATA_W(8), .ADDR_W(4)) f ();

    sync_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(0)) dut_n (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(n)
    );
    sync_fifo #(.DATA_W(8), .ADDR_W(4), .AFULL_TH(14), .AEMPTY_TH(2), .FWFT(1)) dut_f (
        .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(f)
    );

    task automatic tick;
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idle;
        n.wrreq = 0; n.rdreq = 0; n.err_clr = 0; n.data = '0;
        f.wrreq = 0; f.rdreq = 0; f.err_clr = 0; f.data = '0;
    endtask

    task automatic test_reset;
        logic [10:0] got;
        idle();
        sys_rst_n = 0;
        repeat (3) tick();
        got = {n.empty, n.almost_empty, n.full, n.almost_full, n.ovf, n.udf, n.usedw};
        checks++;
        if (got !== 11'b110000_00000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=%b", got, 11'b110000_00000);
        end
        checks++;
        if (n.q !== 8'h00) begin errors++; $display("FAIL reset_q got=%h exp=00", n.q); end
        #2 sys_rst_n = 1;
        tick();
    endtask

    task automatic test_fill;
        for (int i = 1; i <= 16; i++) begin
            n.wrreq = 1; n.data = 8'(i);
            tick();
            checks++;
            if (n.usedw !== 5'(i) || n.full !== (i == 16) || n.almost_full !== (i >= 14) ||
                n.almost_empty !== (i <= 2) || n.empty !== 1'b0) begin
                errors++;
                $display("FAIL fill_%0d got usedw=%0d f=%b af=%b ae=%b e=%b", i, n.usedw,
                         n.full, n.almost_full, n.almost_empty, n.empty);
            end
        end
        n.data = 8'h11;
        tick();
        n.wrreq = 0;
        checks++;
        if (n.usedw !== 5'd16 || n.ovf !== 1'b1 || n.full !== 1'b1) begin
            errors++;
            $display("FAIL overflow got usedw=%0d ovf=%b full=%b exp 16/1/1", n.usedw, n.ovf, n.full);
        end
        n.err_clr = 1;
        tick();
        n.err_clr = 0;
        checks++;
        if (n.ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got=%b exp=0", n.ovf); end
    endtask

    task automatic test_drain;
        for (int i = 1; i <= 16; i++) begin
            n.rdreq = 1;
            tick();
            checks++;
            if (n.q !== 8'(i) || n.usedw !== 5'(16 - i) || n.empty !== (i == 16)) begin
                errors++;
                $display("FAIL drain_%0d got q=%h usedw=%0d e=%b exp q=%h", i, n.q, n.usedw, n.empty, 8'(i));
            end
        end
        tick();
        n.rdreq = 0;
        checks++;
        if (n.udf !== 1'b1 || n.q !== 8'h10 || n.usedw !== 5'd0) begin
            errors++;
            $display("FAIL underflow got udf=%b q=%h usedw=%0d exp 1/10/0", n.udf, n.q, n.usedw);
        end
        n.err_clr = 1;
        tick();
        n.err_clr = 0;
    endtask

    task automatic test_fwft;
        f.wrreq = 1; f.data = 8'hA5;
        tick();
        f.wrreq = 0;
        checks++;
        if (f.q !== 8'hA5 || f.empty !== 1'b0) begin
            errors++;
            $display("FAIL fwft_show got q=%h e=%b exp a5/0", f.q, f.empty);
        end
        f.rdreq = 1;
        tick();
        f.rdreq = 0;
        checks++;
        if (f.empty !== 1'b1 || f.usedw !== 5'd0) begin
            errors++;
            $display("FAIL fwft_ack got e=%b usedw=%0d exp 1/0", f.empty, f.usedw);
        end
        f.wrreq = 1; f.data = 8'h11; tick();
        f.data = 8'h22; tick();
        f.wrreq = 0;
        checks++;
        if (f.q !== 8'h11) begin errors++; $display("FAIL fwft_first got=%h exp=11", f.q); end
        f.rdreq = 1; tick();
        f.rdreq = 0;
        checks++;
        if (f.q !== 8'h22 || f.usedw !== 5'd1) begin
            errors++;
            $display("FAIL fwft_second got q=%h usedw=%0d exp 22/1", f.q, f.usedw);
        end
    endtask

    task automatic test_back_to_back;
        n.wrreq = 1;
        for (int i = 0; i < 5; i++) begin n.data = 8'(8'h30 + i); tick(); end
        n.rdreq = 1;
        for (int i = 0; i < 40; i++) begin
            n.data = 8'(8'h35 + i);
            tick();
            checks++;
            if (n.q !== 8'(8'h30 + i) || n.usedw !== 5'd5) begin
                errors++;
                $display("FAIL stream_%0d got q=%h usedw=%0d exp q=%h usedw=5", i, n.q, n.usedw, 8'(8'h30 + i));
            end
        end
        n.wrreq = 0;
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (n.q !== 8'(8'h58 + k)) begin
                errors++;
                $display("FAIL stream_tail_%0d got=%h exp=%h", k, n.q, 8'(8'h58 + k));
            end
        end
        n.rdreq = 0;
        tick();
    endtask

    task automatic test_simultaneous;
        n.wrreq = 1;
        for (int k = 0; k < 16; k++) begin n.data = 8'(8'h40 + k); tick(); end
        n.rdreq = 1; n.data = 8'hEE;
        tick();
        n.wrreq = 0;
        checks++;
        if (n.usedw !== 5'd15 || n.ovf !== 1'b1 || n.q !== 8'h40) begin
            errors++;
            $display("FAIL simul_full got usedw=%0d ovf=%b q=%h exp 15/1/40", n.usedw, n.ovf, n.q);
        end
        repeat (15) tick();
        n.rdreq = 0;
        checks++;
        if (n.q !== 8'h4F || n.empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_drain got q=%h e=%b exp 4f/1", n.q, n.empty);
        end
        n.wrreq = 1; n.rdreq = 1; n.data = 8'h77;
        tick();
        n.wrreq = 0; n.rdreq = 0;
        checks++;
        if (n.usedw !== 5'd1 || n.udf !== 1'b1 || n.q !== 8'h4F) begin
            errors++;
            $display("FAIL simul_empty got usedw=%0d udf=%b q=%h exp 1/1/4f", n.usedw, n.udf, n.q);
        end
        n.err_clr = 1;
        tick();
        n.err_clr = 0;
        checks++;
        if (n.ovf !== 1'b0 || n.udf !== 1'b0) begin
            errors++;
            $display("FAIL err_clr got ovf=%b udf=%b exp 0/0", n.ovf, n.udf);
        end
        n.rdreq = 1;
        tick();
        checks++;
        if (n.q !== 8'h77 || n.empty !== 1'b1) begin
            errors++;
            $display("FAIL simul_word got q=%h e=%b exp 77/1", n.q, n.empty);
        end
        n.err_clr = 1;
        tick();
        n.rdreq = 0;
        checks++;
        if (n.udf !== 1'b1) begin errors++; $display("FAIL set_wins got udf=%b exp=1", n.udf); end
        tick();
        n.err_clr = 0;
        checks++;
        if (n.udf !== 1'b0) begin errors++; $display("FAIL udf_clear got=%b exp=0", n.udf); end
    endtask

    task automatic test_async_reset;
        logic [10:0] got;
        n.wrreq = 1;
        for (int k = 0; k < 9; k++) begin n.data = 8'(8'h80 + k); tick(); end
        n.wrreq = 0; n.rdreq = 1;
        tick();
        n.rdreq = 0;
        n.wrreq = 1; n.data = 8'h89;
        tick();
        n.wrreq = 0;
        checks++;
        if (n.usedw !== 5'd9 || n.q !== 8'h80) begin
            errors++;
            $display("FAIL pre_reset got usedw=%0d q=%h exp 9/80", n.usedw, n.q);
        end
        #2 sys_rst_n = 0;
        #1;
        got = {n.empty, n.almost_empty, n.full, n.almost_full, n.ovf, n.udf, n.usedw};
        checks++;
        if (got !== 11'b110000_00000 || n.q !== 8'h00) begin
            errors++;
            $display("FAIL async_reset got=%b q=%h exp=%b q=00", got, n.q, 11'b110000_00000);
        end
        #1 sys_rst_n = 1;
        tick();
        n.wrreq = 1; n.data = 8'h99;
        tick();
        n.wrreq = 0; n.rdreq = 1;
        tick();
        n.rdreq = 0;
        checks++;
        if (n.q !== 8'h99 || n.usedw !== 5'd0 || n.empty !== 1'b1) begin
            errors++;
            $display("FAIL post_reset got q=%h usedw=%0d e=%b exp 99/0/1", n.q, n.usedw, n.empty);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_fwft();
        test_back_to_back();
        test_simultaneous();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
